// File: rtl/operand_fetch_stage_if.sv
// ID/EX pipeline register bundle between the operand stage and EX.
// The stage drives the captured instruction; EX answers with ready.
interface operand_fetch_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16
);
  logic              ex_valid;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_d;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [REG_AW-1:0] ex_rw;
  logic              ex_wen;
  logic              ex_ready;

  modport master (
    output ex_valid, ex_a, ex_b, ex_d,
    output ex_ctrl, ex_rw, ex_wen,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_a, ex_b, ex_d,
    input  ex_ctrl, ex_rw, ex_wen,
    output ex_ready
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch: EX/MEM/WB forwarding, load-use detection and the
// ID/EX pipeline register with stall, bubble, flush and stall counter.
module operand_fetch_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              id_use_d,
  input  logic [REG_AW-1:0] id_rw,
  input  logic              id_wr_en,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] pa,
  input  logic [DATA_W-1:0] pb,
  input  logic [DATA_W-1:0] pd,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rw,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_rw,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_rw,
  input  logic [DATA_W-1:0] wb_pw,
  input  logic              flush,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt,
  operand_fetch_stage_if.master ex
);

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] fwd_d;
  logic              hit_a;
  logic              hit_b;
  logic              hit_d;
  logic              load_use;

  // Youngest producer wins; a load in EX has no data yet.
  function automatic logic [DATA_W-1:0] pick(
    input logic [REG_AW-1:0] r,
    input logic [DATA_W-1:0] p
  );
    if (r == '0)
      return '0;
    else if (ex_wr_en && !ex_is_load && ex_rw == r)
      return ex_result;
    else if (mem_wr_en && mem_rw == r)
      return mem_result;
    else if (wb_wr_en && wb_rw == r)
      return wb_pw;
    else
      return p;
  endfunction

  always_comb begin
    fwd_a = pick(id_ra, pa);
    fwd_b = pick(id_rb, pb);
    fwd_d = pick(id_rd, pd);
  end

  assign hit_a = id_use_a && (id_ra == ex_rw);
  assign hit_b = id_use_b && (id_rb == ex_rw);
  assign hit_d = id_use_d && (id_rd == ex_rw);

  assign load_use = id_valid && !flush && ex.ex_valid
                 && ex_wr_en && ex_is_load
                 && (ex_rw != '0)
                 && (hit_a || hit_b || hit_d);

  assign stall = id_valid && (!ex.ex_ready || load_use);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt  <= '0;
      ex.ex_valid <= 1'b0;
      ex.ex_a     <= '0;
      ex.ex_b     <= '0;
      ex.ex_d     <= '0;
      ex.ex_ctrl  <= '0;
      ex.ex_rw    <= '0;
      ex.ex_wen   <= 1'b0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex.ex_ready) begin
        if (flush || load_use) begin
          ex.ex_valid <= 1'b0;
          ex.ex_wen   <= 1'b0;
        end else begin
          ex.ex_valid <= id_valid;
          ex.ex_wen   <= id_wr_en && id_valid;
          ex.ex_a     <= fwd_a;
          ex.ex_b     <= fwd_b;
          ex.ex_d     <= fwd_d;
          ex.ex_ctrl  <= id_ctrl;
          ex.ex_rw    <= id_rw;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: forwarding table plus
// load-use, ready-stall, flush, async reset and counter saturation.
module tb_operand_fetch_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int NW = 4;

  logic          clock;
  logic          reset_n;
  logic          id_valid;
  logic [AW-1:0] id_ra, id_rb, id_rd, id_rw;
  logic          id_use_a, id_use_b, id_use_d, id_wr_en;
  logic [CW-1:0] id_ctrl;
  logic [DW-1:0] pa, pb, pd;
  logic          ex_wr_en, ex_is_load;
  logic [AW-1:0] ex_rw;
  logic [DW-1:0] ex_result;
  logic          mem_wr_en;
  logic [AW-1:0] mem_rw;
  logic [DW-1:0] mem_result;
  logic          wb_wr_en;
  logic [AW-1:0] wb_rw;
  logic [DW-1:0] wb_pw;
  logic          flush;
  logic          stall;
  logic [NW-1:0] stall_cnt;

  int n_chk;
  int n_fail;

  operand_fetch_stage_if #(
    .DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)
  ) exb ();

  operand_fetch_stage #(
    .DATA_W(DW), .REG_AW(AW), .CTRL_W(CW), .CNT_W(NW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .id_valid(id_valid),
    .id_ra(id_ra), .id_rb(id_rb), .id_rd(id_rd),
    .id_use_a(id_use_a), .id_use_b(id_use_b),
    .id_use_d(id_use_d),
    .id_rw(id_rw), .id_wr_en(id_wr_en),
    .id_ctrl(id_ctrl),
    .pa(pa), .pb(pb), .pd(pd),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_rw(ex_rw), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_rw(mem_rw),
    .mem_result(mem_result),
    .wb_wr_en(wb_wr_en), .wb_rw(wb_rw), .wb_pw(wb_pw),
    .flush(flush),
    .stall(stall), .stall_cnt(stall_cnt),
    .ex(exb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] v, uses, ra, rb, rd, pa, pb, pd;
    logic [31:0] exw, exl, exr, exv;
    logic [31:0] mw, mr, mv, ww, wr, wv;
    logic [31:0] wen, rw, ctrl;
    logic [31:0] ea, eb, ed, evld, ewen;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_ra = 0; id_rb = 0; id_rd = 0;
    id_use_a = 0; id_use_b = 0; id_use_d = 0;
    id_rw = 0; id_wr_en = 0; id_ctrl = 0;
    pa = 0; pb = 0; pd = 0;
    ex_wr_en = 0; ex_is_load = 0; ex_rw = 0; ex_result = 0;
    mem_wr_en = 0; mem_rw = 0; mem_result = 0;
    wb_wr_en = 0; wb_rw = 0; wb_pw = 0;
    flush = 0; exb.ex_ready = 1;
  endtask

  task automatic apply(input vec_t t);
    id_valid = t.v[0];
    {id_use_a, id_use_b, id_use_d} = t.uses[2:0];
    id_ra = t.ra[AW-1:0];
    id_rb = t.rb[AW-1:0];
    id_rd = t.rd[AW-1:0];
    pa = t.pa; pb = t.pb; pd = t.pd;
    ex_wr_en = t.exw[0]; ex_is_load = t.exl[0];
    ex_rw = t.exr[AW-1:0]; ex_result = t.exv;
    mem_wr_en = t.mw[0]; mem_rw = t.mr[AW-1:0];
    mem_result = t.mv;
    wb_wr_en = t.ww[0]; wb_rw = t.wr[AW-1:0]; wb_pw = t.wv;
    id_wr_en = t.wen[0]; id_rw = t.rw[AW-1:0];
    id_ctrl = t.ctrl[CW-1:0];
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    // v uses ra rb rd pa pb pd | exw exl exr exv | mw mr mv | ww wr wv
    // | wen rw ctrl | ea eb ed evld ewen
    vt[0] = '{1, 7, 3, 4, 0, 'h14, 'h20, 'hDEAD,
              0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
              1, 10, 'h1111, 'h14, 'h20, 0, 1, 1};
    vt[1] = '{1, 7, 5, 6, 8, 1, 'h66, 'h88,
              1, 0, 5, 'hAA, 1, 5, 'hBB, 1, 5, 'hCC,
              0, 2, 'h2222, 'hAA, 'h66, 'h88, 1, 0};
    vt[2] = '{1, 7, 5, 6, 8, 1, 'h66, 'h88,
              0, 0, 5, 'hAA, 1, 5, 'hBB, 1, 5, 'hCC,
              0, 2, 'h2222, 'hBB, 'h66, 'h88, 1, 0};
    vt[3] = '{1, 7, 5, 6, 8, 1, 'h66, 'h88,
              0, 0, 5, 'hAA, 0, 5, 'hBB, 1, 5, 'hCC,
              0, 2, 'h2222, 'hCC, 'h66, 'h88, 1, 0};
    vt[4] = '{1, 7, 0, 0, 0, 'h99, 'h98, 'h97,
              1, 0, 0, 'hFF, 1, 0, 'hFF, 1, 0, 'hFF,
              1, 0, 3, 0, 0, 0, 1, 1};
    vt[5] = '{1, 0, 5, 9, 5, 'h123, 9, 5,
              1, 1, 5, 'hBAD, 1, 9, 'h77, 0, 0, 0,
              1, 5, 'h5555, 'h123, 'h77, 5, 1, 1};
    vt[6] = '{0, 7, 1, 2, 3, 1, 2, 3,
              1, 1, 1, 'hBAD, 0, 0, 0, 0, 0, 0,
              1, 1, 'h6666, 1, 2, 3, 0, 0};
    vt[7] = '{1, 7, 12, 13, 14, 'hC, 'hD, 'hE,
              1, 0, 14, 'hE0, 1, 13, 'hD0, 1, 12, 'hC0,
              1, 31, 'h7777, 'hC0, 'hD0, 'hE0, 1, 1};

    idle();
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(exb.ex_valid), 0);
    chk("rst_a", exb.ex_a, 0);
    chk("rst_ctrl", 32'(exb.ex_ctrl), 0);
    chk("rst_rw", 32'(exb.ex_rw), 0);
    chk("rst_wen", 32'(exb.ex_wen), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    chk("rst_stall", 32'(stall), 0);
    @(negedge clock);
    reset_n = 1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      apply(vt[i]);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 0);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(exb.ex_valid), vt[i].evld);
      chk($sformatf("v%0d_a", i), exb.ex_a, vt[i].ea);
      chk($sformatf("v%0d_b", i), exb.ex_b, vt[i].eb);
      chk($sformatf("v%0d_d", i), exb.ex_d, vt[i].ed);
      chk($sformatf("v%0d_wen", i), 32'(exb.ex_wen), vt[i].ewen);
      chk($sformatf("v%0d_rw", i), 32'(exb.ex_rw), vt[i].rw);
      chk($sformatf("v%0d_ctrl", i), 32'(exb.ex_ctrl), vt[i].ctrl);
    end

    // load to r7 enters ID/EX
    @(negedge clock);
    idle();
    id_valid = 1; id_wr_en = 1; id_rw = 7; id_ctrl = 7;
    @(posedge clock);
    #1;
    chk("ld_valid", 32'(exb.ex_valid), 1);
    // dependent op: one bubble
    @(negedge clock);
    ex_wr_en = 1; ex_is_load = 1; ex_rw = 7; ex_result = 'hBAD;
    id_rw = 8; id_ctrl = 3; id_ra = 0; id_rb = 7;
    id_use_a = 1; id_use_b = 1; pb = 0;
    #1;
    chk("lu_stall", 32'(stall), 1);
    @(posedge clock);
    #1;
    chk("lu_bubble", 32'(exb.ex_valid), 0);
    chk("lu_wen", 32'(exb.ex_wen), 0);
    chk("lu_cnt", 32'(stall_cnt), 1);
    @(negedge clock);
    ex_wr_en = 0; ex_is_load = 0; ex_rw = 0;
    mem_wr_en = 1; mem_rw = 7; mem_result = 'h55;
    #1;
    chk("lu_stall2", 32'(stall), 0);
    @(posedge clock);
    #1;
    chk("lu_valid2", 32'(exb.ex_valid), 1);
    chk("lu_b", exb.ex_b, 'h55);
    chk("lu_a", exb.ex_a, 0);
    chk("lu_ctrl", 32'(exb.ex_ctrl), 3);

    // EX not ready for 3 cycles
    @(negedge clock);
    idle();
    id_valid = 1; id_ra = 3; pa = 'h31; id_use_a = 1;
    id_ctrl = 4; id_wr_en = 1; id_rw = 3;
    exb.ex_ready = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      chk($sformatf("nr%0d_stall", k), 32'(stall), 1);
      @(posedge clock);
      #1;
      chk($sformatf("nr%0d_b", k), exb.ex_b, 'h55);
      chk($sformatf("nr%0d_ctrl", k), 32'(exb.ex_ctrl), 3);
      chk($sformatf("nr%0d_valid", k), 32'(exb.ex_valid), 1);
    end
    chk("nr_cnt", 32'(stall_cnt), 4);
    @(negedge clock);
    exb.ex_ready = 1;
    #1;
    chk("nr_release", 32'(stall), 0);
    @(posedge clock);
    #1;
    chk("nr_a", exb.ex_a, 'h31);
    chk("nr_ctrl2", 32'(exb.ex_ctrl), 4);
    chk("nr_cnt2", 32'(stall_cnt), 4);

    // flush with a load-use pending
    @(negedge clock);
    ex_wr_en = 1; ex_is_load = 1; ex_rw = 3; flush = 1;
    #1;
    chk("fl_stall", 32'(stall), 0);
    @(posedge clock);
    #1;
    chk("fl_valid", 32'(exb.ex_valid), 0);
    chk("fl_wen", 32'(exb.ex_wen), 0);
    chk("fl_cnt", 32'(stall_cnt), 4);

    // async reset in the middle of a load-use stall
    @(negedge clock);
    flush = 0; ex_wr_en = 0; ex_is_load = 0; ex_rw = 0;
    @(posedge clock);
    #1;
    chk("ar_pre_valid", 32'(exb.ex_valid), 1);
    @(negedge clock);
    ex_wr_en = 1; ex_is_load = 1; ex_rw = 3;
    #1;
    chk("ar_pre_stall", 32'(stall), 1);
    #1;
    reset_n = 0;
    #1;
    chk("ar_valid", 32'(exb.ex_valid), 0);
    chk("ar_a", exb.ex_a, 0);
    chk("ar_cnt", 32'(stall_cnt), 0);
    chk("ar_stall", 32'(stall), 0);
    @(negedge clock);
    reset_n = 1;

    // counter saturation
    idle();
    id_valid = 1;
    exb.ex_ready = 0;
    repeat (20) @(posedge clock);
    #1;
    chk("sat_cnt", 32'(stall_cnt), 15);
    chk("sat_valid", 32'(exb.ex_valid), 0);
    @(negedge clock);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
